// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one byte-wide UART transmitter
// Optional ISSUE-state timeout enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int GNT_W   = 2,
    parameter int TIMEOUT = 64
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   req_ack,
    output logic               uart_send,
    output logic [7:0]         uart_data,
    input  logic               uart_done,
    output logic               grant_valid,
    output logic [GNT_W-1:0]   grant_id,
    output logic               timeout_err
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [GNT_W-1:0] LAST_RST = GNT_W'(N_REQ - 1);
    localparam logic [GNT_W:0]   N_WRAP   = (GNT_W + 1)'(N_REQ);

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   req_q;
    logic [N_REQ-1:0]   req_ack_q, req_ack_d;
    logic               uart_send_q, uart_send_d;
    logic [7:0]         uart_data_q, uart_data_d;
    logic               grant_valid_q, grant_valid_d;
    logic [GNT_W-1:0]   grant_id_q, grant_id_d;
    logic [GNT_W-1:0]   last_grant_q, last_grant_d;
    logic [GNT_W-1:0]   winner;
    logic [GNT_W:0]     idx;
    logic               found;
`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               timeout_err_q, timeout_err_d;
`endif

    // Scan from farthest to nearest so the requester closest after last_grant wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = {1'b0, last_grant_q} + (GNT_W + 1)'(k);
            if (idx >= N_WRAP) idx = idx - N_WRAP;
            if (req_q[idx[GNT_W-1:0]]) begin
                winner = idx[GNT_W-1:0];
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        uart_send_d   = uart_send_q;
        uart_data_d   = uart_data_q;
        grant_valid_d = grant_valid_q;
        grant_id_d    = grant_id_q;
        last_grant_d  = last_grant_q;
        req_ack_d     = '0;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d         = cnt_q;
        timeout_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (found && uart_done) begin
                    uart_data_d   = req_data[8*winner +: 8];
                    grant_id_d    = winner;
                    grant_valid_d = 1'b1;
                    uart_send_d   = 1'b1;
                    state_d       = ISSUE;
`ifdef UART_ARB_TIMEOUT_EN
                    cnt_d         = '0;
`endif
                end
            end
            ISSUE: begin
`ifdef UART_ARB_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
`endif
                if (!uart_done) begin
                    uart_send_d  = 1'b0;
                    req_ack_d    = N_REQ'(1) << grant_id_q;
                    last_grant_d = grant_id_q;
                    state_d      = DRAIN;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    uart_send_d   = 1'b0;
                    timeout_err_d = 1'b1;
                    last_grant_d  = grant_id_q;
                    grant_valid_d = 1'b0;
                    state_d       = IDLE;
                end
`endif
            end
            DRAIN: begin
                if (uart_done) begin
                    grant_valid_d = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: begin
                state_d       = IDLE;
                uart_send_d   = 1'b0;
                uart_data_d   = '0;
                grant_valid_d = 1'b0;
                grant_id_d    = '0;
                last_grant_d  = LAST_RST;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            req_q         <= '0;
            req_ack_q     <= '0;
            uart_send_q   <= 1'b0;
            uart_data_q   <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            last_grant_q  <= LAST_RST;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            req_q         <= req;
            req_ack_q     <= req_ack_d;
            uart_send_q   <= uart_send_d;
            uart_data_q   <= uart_data_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
            last_grant_q  <= last_grant_d;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    assign req_ack     = req_ack_q;
    assign uart_send   = uart_send_q;
    assign uart_data   = uart_data_q;
    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;
`ifdef UART_ARB_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
    localparam int N_REQ   = 4;
    localparam int GNT_W   = 2;
    localparam int TIMEOUT = 16;

    logic               clock = 1'b0;
    logic               reset_n;
    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_ack;
    logic               uart_send;
    logic [7:0]         uart_data;
    logic               uart_done;
    logic               grant_valid;
    logic [GNT_W-1:0]   grant_id;
    logic               timeout_err;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [GNT_W-1:0] id;
        logic [7:0]       data;
    } xfer_t;

    xfer_t            exp_xfer[$];
    logic [N_REQ-1:0] exp_ack[$];

    logic model_en;
    logic model_done;
    logic done_force;
    int   busy;

    assign uart_done = model_en ? model_done : done_force;

    uart_tx_arbiter #(.N_REQ(N_REQ), .GNT_W(GNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req        (req),
        .req_data   (req_data),
        .req_ack    (req_ack),
        .uart_send  (uart_send),
        .uart_data  (uart_data),
        .uart_done  (uart_done),
        .grant_valid(grant_valid),
        .grant_id   (grant_id),
        .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // UART model: accepts a byte when send is seen while idle, busy for 3 cycles.
    initial begin
        model_done = 1'b1;
        busy       = 0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                model_done = 1'b1;
                busy       = 0;
            end else if (model_en) begin
                if (model_done && uart_send) begin
                    model_done = 1'b0;
                    busy       = 3;
                end else if (!model_done) begin
                    busy = busy - 1;
                    if (busy == 0) model_done = 1'b1;
                end
            end
        end
    end

    // Monitor: pops expected transfer on each rising uart_send, expected ack on each ack.
    initial begin
        xfer_t e;
        logic  send_prev;
        send_prev = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                send_prev = 1'b0;
            end else begin
                if (uart_send && !send_prev) begin
                    if (exp_xfer.size() == 0) begin
                        check("unexpected_send", 32'(grant_id), 32'hFFFF);
                    end else begin
                        e = exp_xfer.pop_front();
                        check("grant_id", 32'(grant_id), 32'(e.id));
                        check("uart_data", 32'(uart_data), 32'(e.data));
                        check("grant_valid_on_send", 32'(grant_valid), 32'd1);
                    end
                end
                send_prev = uart_send;
                if (req_ack != '0) begin
                    check("ack_onehot", 32'($onehot(req_ack)), 32'd1);
                    if (exp_ack.size() == 0)
                        check("unexpected_ack", 32'(req_ack), 32'd0);
                    else
                        check("req_ack", 32'(req_ack), 32'(exp_ack.pop_front()));
                end
            end
        end
    end

    task automatic wait_acks(input int n, input int budget);
        int got;
        got = 0;
        for (int c = 0; c < budget && got < n; c++) begin
            @(negedge clock);
            if (req_ack != '0) got++;
        end
        check("ack_count", 32'(got), 32'(n));
    endtask

    task automatic wait_idle(input int budget);
        int c;
        c = 0;
        while ((grant_valid || uart_send) && c < budget) begin
            @(negedge clock);
            c++;
        end
        check("idle_reached", 32'(grant_valid || uart_send), 32'd0);
    endtask

    task automatic wait_send(input int budget);
        int c;
        c = 0;
        while (!uart_send && c < budget) begin
            @(negedge clock);
            c++;
        end
        check("send_seen", 32'(uart_send), 32'd1);
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset_n = 1'b0;
        req     = '0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic push(input int id, input logic [7:0] data);
        xfer_t e;
        e.id   = GNT_W'(id);
        e.data = data;
        exp_xfer.push_back(e);
    endtask

    initial begin
        int n;
        reset_n    = 1'b0;
        req        = '0;
        req_data   = 32'h0000_0055;
        model_en   = 1'b1;
        done_force = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_uart_send", 32'(uart_send), 32'd0);
        check("rst_uart_data", 32'(uart_data), 32'd0);
        check("rst_req_ack", 32'(req_ack), 32'd0);
        check("rst_grant_valid", 32'(grant_valid), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // 1: single requester, latency and ack
        push(0, 8'h55);
        exp_ack.push_back(4'b0001);
        req = 4'b0001;
        @(negedge clock);
        check("t1_send_edge_k", 32'(uart_send), 32'd0);
        @(negedge clock);
        check("t1_send_edge_k1", 32'(uart_send), 32'd1);
        wait_acks(1, 20);
        req = '0;
        check("t1_gv_in_drain", 32'(grant_valid), 32'd1);
        wait_idle(20);

        // 2: all requesting, round-robin order over two rounds
        apply_reset();
        req_data = 32'hA3A2_A1A0;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N_REQ; i++) begin
                push(i, 8'hA0 + 8'(i));
                exp_ack.push_back(N_REQ'(1) << i);
            end
        req = 4'b1111;
        wait_acks(8, 200);
        req = '0;
        wait_idle(20);

        // 3: last_grant=1 then req=1010 -> 3 then 1
        push(1, 8'hA1);
        exp_ack.push_back(4'b0010);
        req = 4'b0010;
        wait_acks(1, 30);
        req = '0;
        wait_idle(20);
        push(3, 8'hA3);
        push(1, 8'hA1);
        exp_ack.push_back(4'b1000);
        exp_ack.push_back(4'b0010);
        req = 4'b1010;
        wait_acks(1, 30);
        req = 4'b0010;
        wait_acks(1, 30);
        req = '0;
        wait_idle(20);

        // 4: uart_done low at reset release holds off the grant
        model_en   = 1'b0;
        done_force = 1'b0;
        apply_reset();
        req = 4'b0001;
        n = 0;
        repeat (6) begin
            @(negedge clock);
            if (uart_send || grant_valid) n++;
        end
        check("t4_no_grant_while_busy", 32'(n), 32'd0);
        push(0, 8'hA0);
        exp_ack.push_back(4'b0001);
        model_en = 1'b1;
        @(negedge clock);
        check("t4_send_after_done", 32'(uart_send), 32'd1);
        wait_acks(1, 20);
        req = '0;
        wait_idle(20);

        // 5: reset during DRAIN
        push(0, 8'hA0);
        exp_ack.push_back(4'b0001);
        req = 4'b0001;
        wait_acks(1, 30);
        req = '0;
        @(negedge clock);
        check("t5_in_drain", 32'(grant_valid && !uart_send), 32'd1);
        reset_n = 1'b0;
        #1;
        check("t5_rst_outputs", 32'({uart_send, uart_data, req_ack, grant_valid, grant_id, timeout_err}), 32'd0);
        @(negedge clock);
        req = 4'b1111;
        push(0, 8'hA0);
        exp_ack.push_back(4'b0001);
        @(negedge clock);
        reset_n = 1'b1;
        wait_acks(1, 30);
        req = '0;
        wait_idle(20);

        // 6: uart_done stuck high
        model_en   = 1'b0;
        done_force = 1'b1;
        apply_reset();
        push(0, 8'hA0);
`ifdef UART_ARB_TIMEOUT_EN
        push(1, 8'hA1);
`endif
        req = 4'b0011;
        wait_send(10);
`ifdef UART_ARB_TIMEOUT_EN
        n = 0;
        while (!timeout_err && n < 40) begin
            @(negedge clock);
            n++;
        end
        check("t6_timeout_cycles", 32'(n), 32'd16);
        @(negedge clock);
        @(negedge clock);
        check("t6_next_send", 32'(uart_send), 32'd1);
        check("t6_next_grant", 32'(grant_id), 32'd1);
`else
        n = 0;
        repeat (40) begin
            @(negedge clock);
            if (timeout_err || !uart_send) n++;
        end
        check("t6_send_held_no_timeout", 32'(n), 32'd0);
        check("t6_grant_id", 32'(grant_id), 32'd0);
`endif
        model_en = 1'b1;
        apply_reset();
        repeat (3) @(negedge clock);

        check("xfer_queue_empty", 32'(exp_xfer.size()), 32'd0);
        check("ack_queue_empty", 32'(exp_ack.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
